pwm_duty_sequencer: RTL
=======================

// Module: pwm_duty_sequencer
// PURPOSE
//  Sequences the duty command of the PWMunsigned generator for the pendulum drive.
//  Arbitrates duty-change requests from two sources: A = control loop (priority), B = manual/test.
//  Slews duty_out toward the accepted target by at most MAX_STEP per PWM period.
//  Applies each change only at a period boundary, so no PWM period is ever truncated or glitched.
// PARAMETERS
//  PWM_IN_SIZE  4  width of duty and count; must match the PWM generator's PWM_IN_SIZE
//  MAX_STEP     1  max |duty change| per PWM period; legal range 1..2^PWM_IN_SIZE-1
//  RESET_DUTY   0  duty_out and target value after reset
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   synchronous, active-high
//  req_a      in   1   requester A wants new duty; held until ack_a
//  duty_a     in   W   requested duty from A; stable while req_a=1 (W = PWM_IN_SIZE)
//  ack_a      out  1   one-cycle accept pulse to A
//  req_b      in   1   requester B wants new duty; held until ack_b
//  duty_b     in   W   requested duty from B; stable while req_b=1
//  ack_b      out  1   one-cycle accept pulse to B
//  pwm_count  in   W   free-running period counter from the PWM generator
//  duty_out   out  W   duty command; drives the PWM generator's data_in
//  pwm_enable out  1   enable to the PWM generator
//  busy       out  1   1 while duty_out != target (ramp in progress)
// BEHAVIOUR
//  Reset (sync, high): duty_out=target=RESET_DUTY, ack_a=ack_b=0, busy=0, pwm_enable=0, state=IDLE.
//   Reset mid-ramp abandons the ramp and takes these values on the same edge.
//   Requests held during reset are not acked until the first cycle after release.
//  pwm_enable: registered ~reset; goes 1 on the first edge after reset is released.
//  Arbitration (every cycle, any state), fixed priority:
//   - A is eligible if req_a=1 and ack_a=0; B is eligible if req_b=1 and ack_b=0.
//   - When A is eligible, it wins: on that edge target<=duty_a and ack_a<=1.
//   - Otherwise an eligible B wins: target<=duty_b and ack_b<=1.
//   - At most one ack per cycle; a losing requester stays pending and is served next free cycle.
//   - Ack latency: 1 clk after req is sampled high; the ack is a 1-cycle pulse.
//   - A later acceptance overwrites target (last accepted wins), including during RAMP.
//  Boundary strobe: bnd = (pwm_count == 2^W-1). duty_out changes only on edges where bnd=1.
//   The new duty therefore applies from count 0 of the next period.
//  FSM: IDLE (duty_out==target) / RAMP (duty_out!=target).
//   - IDLE->RAMP: on the edge after target differs from duty_out; busy follows state.
//   - RAMP, at bnd: diff = target-duty_out, computed in W+1-bit signed.
//     - If |diff| <= MAX_STEP: duty_out<=target and go to IDLE.
//     - Otherwise: duty_out <= duty_out +/- MAX_STEP, toward target.
//     - The result is never outside 0..2^W-1; no wrap-around.
//   - Request equal to current duty_out: acked normally; stays IDLE, busy stays 0.
//   - Retarget in RAMP: direction is recomputed at the next bnd.
//     A retarget back to duty_out returns to IDLE on the next edge.
//   - Acceptance and bnd on the same edge: the step uses the OLD target; the new target acts from the next bnd.
// TESTING (W=4, MAX_STEP=1 unless stated; period = 16 clk)
//  1 Reset: hold reset 2 clk -> duty_out=0, acks=0, busy=0, pwm_enable=0.
//    First edge after release -> pwm_enable=1.
//  2 Ramp up: req_a, duty_a=3 at pwm_count=5.
//    -> ack_a pulse next clk, busy=1.
//    -> duty_out = 1, 2, 3 on the next three count=15 edges, then busy=0.
//  3 Contention: req_a (duty_a=8) and req_b (duty_b=2) raised on the same cycle.
//    -> ack_a first, ack_b the following cycle; final duty_out settles at 2.
//  4 Retarget (MAX_STEP=4): 0 -> target 15 gives duty 4, then 8; retarget to 5.
//    -> duty_out=5 at the next boundary, busy=0.
//  5 Reset mid-ramp: duty_out=6 ramping to 12; assert reset.
//    -> duty_out=0 and busy=0 on that edge; no further change without a new request.
//  6 Glitch-free check: random requests over 200 periods.
//    -> duty_out changes only on count=15 edges; |step| <= MAX_STEP.

Source files
------------

// File: rtl/pwm_duty_sequencer.sv
// Duty-command sequencer for the pendulum PWM drive: arbitrates two requesters
// and slews duty_out toward the accepted target, changing only at period boundaries.
module pwm_duty_sequencer #(
   parameter int unsigned PWM_IN_SIZE = 4,
   parameter int unsigned MAX_STEP    = 1,
   parameter int unsigned RESET_DUTY  = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_a,
   input  logic [PWM_IN_SIZE-1:0] duty_a,
   output logic                   ack_a,
   input  logic                   req_b,
   input  logic [PWM_IN_SIZE-1:0] duty_b,
   output logic                   ack_b,
   input  logic [PWM_IN_SIZE-1:0] pwm_count,
   output logic [PWM_IN_SIZE-1:0] duty_out,
   output logic                   pwm_enable,
   output logic                   busy
);

   localparam int unsigned W = PWM_IN_SIZE;
   localparam logic [W-1:0] CNT_MAX = '1;
   localparam logic [W-1:0] STEP_W  = W'(MAX_STEP);
   localparam logic [W:0]   STEP_X  = (W+1)'(MAX_STEP);
   localparam logic [W-1:0] RST_W   = W'(RESET_DUTY);

   typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   duty_q, duty_d;
   logic [W-1:0]   target_q, target_d;
   logic           ack_a_q, ack_a_d;
   logic           ack_b_q, ack_b_d;
   logic           pwm_enable_q, pwm_enable_d;

   logic           bnd;
   logic signed [W:0] diff;
   logic [W:0]     mag;

   // Arbitration, boundary detection and slew FSM.
   always_comb begin
      state_d      = state_q;
      duty_d       = duty_q;
      target_d     = target_q;
      ack_a_d      = 1'b0;
      ack_b_d      = 1'b0;
      pwm_enable_d = 1'b1;

      bnd  = (pwm_count == CNT_MAX);
      diff = $signed({1'b0, target_q}) - $signed({1'b0, duty_q});
      mag  = diff[W] ? (W+1)'(-diff) : (W+1)'(diff);

      // Fixed priority: A over B; a requester is blocked while its ack is high.
      if (req_a && !ack_a_q) begin
         target_d = duty_a;
         ack_a_d  = 1'b1;
      end else if (req_b && !ack_b_q) begin
         target_d = duty_b;
         ack_b_d  = 1'b1;
      end

      // Steps use the current target; a same-edge acceptance acts from the next boundary.
      case (state_q)
         IDLE: begin
            if (target_q != duty_q) state_d = RAMP;
         end
         RAMP: begin
            if (target_q == duty_q) begin
               state_d = IDLE;
            end else if (bnd) begin
               if (mag <= STEP_X) begin
                  duty_d  = target_q;
                  state_d = IDLE;
               end else if (diff[W]) begin
                  duty_d = duty_q - STEP_W;
               end else begin
                  duty_d = duty_q + STEP_W;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         duty_q       <= RST_W;
         target_q     <= RST_W;
         ack_a_q      <= 1'b0;
         ack_b_q      <= 1'b0;
         pwm_enable_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         duty_q       <= duty_d;
         target_q     <= target_d;
         ack_a_q      <= ack_a_d;
         ack_b_q      <= ack_b_d;
         pwm_enable_q <= pwm_enable_d;
      end
   end

   assign ack_a      = ack_a_q;
   assign ack_b      = ack_b_q;
   assign duty_out   = duty_q;
   assign pwm_enable = pwm_enable_q;
   assign busy       = (state_q == RAMP);

endmodule
